// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_pkg;

   localparam int DW         = 32;
   localparam int AW         = 5;
   localparam int FIFO_DEPTH = 4;

   localparam logic BANK_A = 1'b0;
   localparam logic BANK_B = 1'b1;

   typedef struct packed {
      logic          bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_req_t;

   // Which core wins the next same bank+addr collision.
   typedef enum logic {
      RR_CORE1 = 1'b0,
      RR_CORE2 = 1'b1
   } rr_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-core writeback request FIFO; head is visible combinationally while not empty.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter type T     = wb_req_t,
   parameter int  DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  T     push_data,
   input  logic pop,
   output T     head,
   output logic empty,
   output logic full
);

   localparam int PW = $clog2(DEPTH);

   T            mem [DEPTH];
   logic [PW:0] wr_ptr;
   logic [PW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   // Extra MSB on each pointer is the wrap bit that separates full from empty.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the dual-bank register file: per-core FIFOs and
// round-robin resolution of same bank+addr collisions. WB_STATS_EN adds coll_cnt/stall_cnt.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DW         = regfile_pkg::DW,
   parameter int AW         = regfile_pkg::AW,
   parameter int FIFO_DEPTH = regfile_pkg::FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_valid1,
   output logic          wb_ready1,
   input  logic          wb_bank1,
   input  logic [AW-1:0] wb_addr1,
   input  logic [DW-1:0] wb_data1,
   input  logic          wb_valid2,
   output logic          wb_ready2,
   input  logic          wb_bank2,
   input  logic [AW-1:0] wb_addr2,
   input  logic [DW-1:0] wb_data2,
   output logic          wr_en_a1,
   output logic [AW-1:0] wr_addr_a1,
   output logic [DW-1:0] wr_data_a1,
   output logic          wr_en_a2,
   output logic [AW-1:0] wr_addr_a2,
   output logic [DW-1:0] wr_data_a2,
   output logic          wr_en_b1,
   output logic [AW-1:0] wr_addr_b1,
   output logic [DW-1:0] wr_data_b1,
   output logic          wr_en_b2,
   output logic [AW-1:0] wr_addr_b2,
   output logic [DW-1:0] wr_data_b2,
   output logic          idle
`ifdef WB_STATS_EN
   ,
   output logic [15:0]   coll_cnt,
   output logic [15:0]   stall_cnt
`endif
);

   typedef struct packed {
      logic          bank;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } req_t;

   req_t head1;
   req_t head2;
   req_t in1;
   req_t in2;
   logic empty1;
   logic empty2;
   logic full1;
   logic full2;
   logic coll;
   logic issue1;
   logic issue2;
   logic sel_a1;
   logic sel_b1;
   logic sel_a2;
   logic sel_b2;
   rr_t  rr_q;
   rr_t  rr_d;

   assign in1       = '{bank: wb_bank1, addr: wb_addr1, data: wb_data1};
   assign in2       = '{bank: wb_bank2, addr: wb_addr2, data: wb_data2};
   assign wb_ready1 = !full1;
   assign wb_ready2 = !full2;

   wb_fifo #(
      .T     (req_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wb_valid1 && wb_ready1),
      .push_data (in1),
      .pop       (issue1),
      .head      (head1),
      .empty     (empty1),
      .full      (full1)
   );

   wb_fifo #(
      .T     (req_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (wb_valid2 && wb_ready2),
      .push_data (in2),
      .pop       (issue2),
      .head      (head2),
      .empty     (empty2),
      .full      (full2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_q <= RR_CORE1;
      else        rr_q <= rr_d;
   end

   // Only the current heads take part; a losing head simply stays in its FIFO.
   always_comb begin
      coll   = !empty1 && !empty2 && (head1.bank == head2.bank) && (head1.addr == head2.addr);
      issue1 = !empty1 && (!coll || (rr_q == RR_CORE1));
      issue2 = !empty2 && (!coll || (rr_q == RR_CORE2));
      rr_d   = rr_q;
      if (coll) rr_d = (rr_q == RR_CORE1) ? RR_CORE2 : RR_CORE1;
      sel_a1 = issue1 && (head1.bank == BANK_A);
      sel_b1 = issue1 && (head1.bank == BANK_B);
      sel_a2 = issue2 && (head2.bank == BANK_A);
      sel_b2 = issue2 && (head2.bank == BANK_B);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_a1   <= 1'b0;
         wr_addr_a1 <= '0;
         wr_data_a1 <= '0;
         wr_en_b1   <= 1'b0;
         wr_addr_b1 <= '0;
         wr_data_b1 <= '0;
         wr_en_a2   <= 1'b0;
         wr_addr_a2 <= '0;
         wr_data_a2 <= '0;
         wr_en_b2   <= 1'b0;
         wr_addr_b2 <= '0;
         wr_data_b2 <= '0;
      end else begin
         wr_en_a1   <= sel_a1;
         wr_addr_a1 <= sel_a1 ? head1.addr : '0;
         wr_data_a1 <= sel_a1 ? head1.data : '0;
         wr_en_b1   <= sel_b1;
         wr_addr_b1 <= sel_b1 ? head1.addr : '0;
         wr_data_b1 <= sel_b1 ? head1.data : '0;
         wr_en_a2   <= sel_a2;
         wr_addr_a2 <= sel_a2 ? head2.addr : '0;
         wr_data_a2 <= sel_a2 ? head2.data : '0;
         wr_en_b2   <= sel_b2;
         wr_addr_b2 <= sel_b2 ? head2.addr : '0;
         wr_data_b2 <= sel_b2 ? head2.data : '0;
      end
   end

   assign idle = empty1 && empty2 && !(wr_en_a1 || wr_en_b1 || wr_en_a2 || wr_en_b2);

`ifdef WB_STATS_EN
   logic stall;

   assign stall = (wb_valid1 && !wb_ready1) || (wb_valid2 && !wb_ready2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coll_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (coll && (coll_cnt != '1))   coll_cnt  <= coll_cnt + 1'b1;
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus scoreboarded sequences.
module tb_regfile_wb_arbiter;

   localparam int TDW    = 32;
   localparam int TAW    = 5;
   localparam int TDEPTH = 4;

   typedef struct packed {
      logic           bank;
      logic [TAW-1:0] addr;
      logic [TDW-1:0] data;
   } req_t;

   typedef struct {
      logic       v1;
      req_t       r1;
      logic       v2;
      req_t       r2;
      logic [3:0] exp1;
      logic [3:0] exp2;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           wb_valid1, wb_ready1, wb_bank1;
   logic [TAW-1:0] wb_addr1;
   logic [TDW-1:0] wb_data1;
   logic           wb_valid2, wb_ready2, wb_bank2;
   logic [TAW-1:0] wb_addr2;
   logic [TDW-1:0] wb_data2;
   logic           wr_en_a1, wr_en_a2, wr_en_b1, wr_en_b2;
   logic [TAW-1:0] wr_addr_a1, wr_addr_a2, wr_addr_b1, wr_addr_b2;
   logic [TDW-1:0] wr_data_a1, wr_data_a2, wr_data_b1, wr_data_b2;
   logic           idle;
   logic [3:0]     strb;
`ifdef WB_STATS_EN
   logic [15:0]    coll_cnt, stall_cnt;
   logic [15:0]    exp_coll = '0;
   logic [15:0]    exp_stall = '0;
`endif

   req_t q1[$];
   req_t q2[$];
   int   checks = 0;
   int   errors = 0;
   logic saw_full1 = 1'b0;
   vec_t vecs[8];

   always #5 clk = ~clk;

   assign strb = {wr_en_a1, wr_en_b1, wr_en_a2, wr_en_b2};

   regfile_wb_arbiter #(
      .DW         (TDW),
      .AW         (TAW),
      .FIFO_DEPTH (TDEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_valid1  (wb_valid1),
      .wb_ready1  (wb_ready1),
      .wb_bank1   (wb_bank1),
      .wb_addr1   (wb_addr1),
      .wb_data1   (wb_data1),
      .wb_valid2  (wb_valid2),
      .wb_ready2  (wb_ready2),
      .wb_bank2   (wb_bank2),
      .wb_addr2   (wb_addr2),
      .wb_data2   (wb_data2),
      .wr_en_a1   (wr_en_a1),
      .wr_addr_a1 (wr_addr_a1),
      .wr_data_a1 (wr_data_a1),
      .wr_en_a2   (wr_en_a2),
      .wr_addr_a2 (wr_addr_a2),
      .wr_data_a2 (wr_data_a2),
      .wr_en_b1   (wr_en_b1),
      .wr_addr_b1 (wr_addr_b1),
      .wr_data_b1 (wr_data_b1),
      .wr_en_b2   (wr_en_b2),
      .wr_addr_b2 (wr_addr_b2),
      .wr_data_b2 (wr_data_b2),
      .idle       (idle)
`ifdef WB_STATS_EN
      ,
      .coll_cnt   (coll_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   function automatic req_t mk(input logic bank, input logic [TAW-1:0] addr, input logic [TDW-1:0] data);
      req_t r;
      r.bank = bank;
      r.addr = addr;
      r.data = data;
      return r;
   endfunction

   // Scoreboard: accepted requests queue per core; every strobe must match the oldest one.
   always @(negedge clk) begin : monitor
      req_t e;
      if (rst_n) begin
         if (strb[3] || strb[2]) begin
            check("core1_single_port", 64'(strb[3] && strb[2]), 64'(0));
            check("core1_entry_pending", 64'(q1.size() != 0), 64'(1));
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check("core1_bank", 64'(strb[2]), 64'(e.bank));
               check("core1_addr", 64'(strb[3] ? wr_addr_a1 : wr_addr_b1), 64'(e.addr));
               check("core1_data", 64'(strb[3] ? wr_data_a1 : wr_data_b1), 64'(e.data));
            end
         end
         if (strb[1] || strb[0]) begin
            check("core2_single_port", 64'(strb[1] && strb[0]), 64'(0));
            check("core2_entry_pending", 64'(q2.size() != 0), 64'(1));
            if (q2.size() != 0) begin
               e = q2.pop_front();
               check("core2_bank", 64'(strb[0]), 64'(e.bank));
               check("core2_addr", 64'(strb[1] ? wr_addr_a2 : wr_addr_b2), 64'(e.addr));
               check("core2_data", 64'(strb[1] ? wr_data_a2 : wr_data_b2), 64'(e.data));
            end
         end
         if (!strb[3]) check("a1_unstrobed_zero", 64'({wr_addr_a1, wr_data_a1}), 64'(0));
         if (!strb[2]) check("b1_unstrobed_zero", 64'({wr_addr_b1, wr_data_b1}), 64'(0));
         if (!strb[1]) check("a2_unstrobed_zero", 64'({wr_addr_a2, wr_data_a2}), 64'(0));
         if (!strb[0]) check("b2_unstrobed_zero", 64'({wr_addr_b2, wr_data_b2}), 64'(0));
         check("ready1", 64'(wb_ready1), 64'(q1.size() < TDEPTH));
         check("ready2", 64'(wb_ready2), 64'(q2.size() < TDEPTH));
         check("idle", 64'(idle), 64'(q1.size() == 0 && q2.size() == 0 && strb == 4'b0));
         if (!wb_ready1) saw_full1 = 1'b1;
`ifdef WB_STATS_EN
         check("coll_cnt", 64'(coll_cnt), 64'(exp_coll));
         check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
         if (q1.size() != 0 && q2.size() != 0 && q1[0].bank == q2[0].bank &&
             q1[0].addr == q2[0].addr && exp_coll != 16'hFFFF) exp_coll++;
         if (((wb_valid1 && !wb_ready1) || (wb_valid2 && !wb_ready2)) && exp_stall != 16'hFFFF)
            exp_stall++;
`endif
         if (wb_valid1 && wb_ready1) q1.push_back(mk(wb_bank1, wb_addr1, wb_data1));
         if (wb_valid2 && wb_ready2) q2.push_back(mk(wb_bank2, wb_addr2, wb_data2));
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_strobes"}, 64'(strb), 64'(0));
      check({tag, "_port1_addr_data"}, 64'({wr_addr_a1, wr_addr_b1, wr_data_a1}), 64'(0));
      check({tag, "_port2_addr_data"}, 64'({wr_addr_a2, wr_addr_b2, wr_data_a2}), 64'(0));
      check({tag, "_b_data"}, 64'({wr_data_b1, wr_data_b2}), 64'(0));
      check({tag, "_ready"}, 64'({wb_ready1, wb_ready2}), 64'(2'b11));
      check({tag, "_idle"}, 64'(idle), 64'(1));
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(posedge clk); #1;
      wb_valid1 = v.v1;
      {wb_bank1, wb_addr1, wb_data1} = v.r1;
      wb_valid2 = v.v2;
      {wb_bank2, wb_addr2, wb_data2} = v.r2;
      @(posedge clk); #1;
      wb_valid1 = 1'b0;
      wb_valid2 = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_no_strobe_yet", idx), 64'(strb), 64'(0));
      @(negedge clk);
      check($sformatf("vec%0d_first_strobes", idx), 64'(strb), 64'(v.exp1));
      @(negedge clk);
      check($sformatf("vec%0d_second_strobes", idx), 64'(strb), 64'(v.exp2));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", idx), 64'(idle), 64'(1));
   endtask

   task automatic send1(input req_t r);
      int n = 0;
      wb_valid1 = 1'b1;
      {wb_bank1, wb_addr1, wb_data1} = r;
      @(negedge clk);
      while (!wb_ready1 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("send1_accept_in_time", 64'(n < 50), 64'(1));
      @(posedge clk); #1;
      wb_valid1 = 1'b0;
   endtask

   task automatic send2(input req_t r);
      int n = 0;
      wb_valid2 = 1'b1;
      {wb_bank2, wb_addr2, wb_data2} = r;
      @(negedge clk);
      while (!wb_ready2 && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("send2_accept_in_time", 64'(n < 50), 64'(1));
      @(posedge clk); #1;
      wb_valid2 = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while (!(idle && q1.size() == 0 && q2.size() == 0) && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({tag, "_drained"}, 64'(n < 200), 64'(1));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_valid1 = 1'b0; wb_bank1 = 1'b0; wb_addr1 = '0; wb_data1 = '0;
      wb_valid2 = 1'b0; wb_bank2 = 1'b0; wb_addr2 = '0; wb_data2 = '0;

      // {en_a1, en_b1, en_a2, en_b2} one and two cycles after the accept edge.
      vecs[0] = '{1'b1, mk(1'b0, 5'd3, 32'hDEADBEEF), 1'b0, mk(1'b0, 5'd0, 32'h0), 4'b1000, 4'b0000};
      vecs[1] = '{1'b1, mk(1'b0, 5'd7, 32'h11), 1'b1, mk(1'b0, 5'd7, 32'h22), 4'b1000, 4'b0010};
      vecs[2] = '{1'b1, mk(1'b0, 5'd7, 32'h33), 1'b1, mk(1'b0, 5'd7, 32'h44), 4'b0010, 4'b1000};
      vecs[3] = '{1'b1, mk(1'b0, 5'd5, 32'h1), 1'b1, mk(1'b1, 5'd5, 32'h2), 4'b1001, 4'b0000};
      vecs[4] = '{1'b1, mk(1'b1, 5'd9, 32'hAAAA0001), 1'b1, mk(1'b1, 5'd9, 32'hBBBB0002), 4'b0100, 4'b0001};
      vecs[5] = '{1'b1, mk(1'b0, 5'd4, 32'h4), 1'b1, mk(1'b0, 5'd5, 32'h5), 4'b1010, 4'b0000};
      vecs[6] = '{1'b0, mk(1'b0, 5'd0, 32'h0), 1'b1, mk(1'b1, 5'd31, 32'hFFFFFFFF), 4'b0001, 4'b0000};
      vecs[7] = '{1'b1, mk(1'b1, 5'd0, 32'hC0), 1'b1, mk(1'b0, 5'd0, 32'hC1), 4'b0110, 4'b0000};

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);
`ifdef WB_STATS_EN
      check("coll_cnt_after_table", 64'(coll_cnt), 64'(3));
`endif

      // Both cores hammer A[1]; alternating wins let core1 fill and back-pressure.
      fork
         begin
            for (int i = 0; i < 7; i++) send1(mk(1'b0, 5'd1, 32'h1000 + i));
         end
         begin
            for (int j = 0; j < 8; j++) send2(mk(1'b0, 5'd1, 32'h2000 + j));
         end
      join
      wait_drain("burst");
      check("ready1_dropped_when_full", 64'(saw_full1), 64'(1));

      // Reset with requests still queued.
      fork
         begin
            for (int i = 0; i < 3; i++) send1(mk(1'b0, 5'd2, 32'h3000 + i));
         end
         begin
            for (int j = 0; j < 3; j++) send2(mk(1'b0, 5'd2, 32'h4000 + j));
         end
      join
      check("queued_before_reset", 64'(idle), 64'(0));
      rst_n = 1'b0;
      q1.delete();
      q2.delete();
`ifdef WB_STATS_EN
      exp_coll = '0;
      exp_stall = '0;
`endif
      #1;
      check_reset_outputs("midreset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("post_reset");
      apply_vec('{1'b1, mk(1'b0, 5'd7, 32'h55), 1'b1, mk(1'b0, 5'd7, 32'h66), 4'b1000, 4'b0010}, 8);

`ifdef WB_STATS_EN
      @(posedge clk); #1;
      wb_valid1 = 1'b1;
      {wb_bank1, wb_addr1, wb_data1} = mk(1'b0, 5'd0, 32'h5A);
      wb_valid2 = 1'b1;
      {wb_bank2, wb_addr2, wb_data2} = mk(1'b0, 5'd0, 32'hA5);
      repeat (70100) @(posedge clk);
      #1;
      wb_valid1 = 1'b0;
      wb_valid2 = 1'b0;
      wait_drain("saturate");
      check("coll_cnt_saturated", 64'(coll_cnt), 64'(16'hFFFF));
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
